// File: rtl/multicycle_ctrl_fsm_pkg.sv
// ctrl_pkg: shared encodings for the multi-cycle RV32I control unit.
// Holds opcodes, the FSM state enum, ALU operation codes and mux selects.
package ctrl_pkg;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_WB     = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM    = 4'd5,
        S_LDWB   = 4'd6,
        S_BRANCH = 4'd7,
        S_TRAP   = 4'd8
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    localparam logic [1:0] PC_SRC_PC4 = 2'b00;
    localparam logic [1:0] PC_SRC_TGT = 2'b01;

    localparam logic [1:0] ALUB_RS2  = 2'b00;
    localparam logic [1:0] ALUB_IMM  = 2'b01;
    localparam logic [1:0] ALUB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// multicycle_ctrl_fsm_if: instruction/data memory handshake bundle.
// master = control FSM (issues requests), slave = memory side.
interface multicycle_ctrl_fsm_if;
    logic [31:0] instr;
    logic        imem_req;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  instr, imem_ready, dmem_ready
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output instr, imem_ready, dmem_ready
    );
endinterface

// File: rtl/multicycle_ctrl_fsm_alu_op_decode.sv
// alu_op_decode: {opcode, funct7[5], funct3} -> 4-bit ALU operation for EXEC.
// Anything that is not R/I-type, or an unlisted funct3, falls back to ADD.
module alu_op_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic       f7b5,
    input  logic [2:0] funct3,
    output logic [3:0] alu_ctr
);

    logic is_r;
    assign is_r = (opcode == OP_R);

    // funct3 table; bit 30 only selects SUB (R-type) and SRA/SRAI
    always_comb begin
        alu_ctr = ALU_ADD;
        if (is_r || opcode == OP_I) begin
            case (funct3)
                3'b000:  alu_ctr = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_ctr = ALU_SLL;
                3'b010:  alu_ctr = ALU_SLT;
                3'b100:  alu_ctr = ALU_XOR;
                3'b101:  alu_ctr = f7b5 ? ALU_SRA : ALU_SRL;
                3'b110:  alu_ctr = ALU_OR;
                3'b111:  alu_ctr = ALU_AND;
                default: alu_ctr = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multi-cycle RV32I control unit.
// FETCH/DECODE/EXEC/WB, ADDR/MEM/LDWB and BRANCH sequencing with memory
// ready handshakes and an instructions-retired counter.
// Build option ILLEGAL_TRAP_EN: illegal opcodes park in TRAP and raise
// illegal_o; without it they retire as NOPs.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int RET_W    = 32,
    parameter int ALUCTR_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_fsm_if.master mem,
    input  logic                alu_zero,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUCTR_W-1:0] alu_ctr,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                tgt_write,
    output logic [RET_W-1:0]    instret,
    output logic [3:0]          state_o
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic                illegal_o
`endif
);

    state_t     state, state_nxt;
    logic       retire;
    // Only the fields the control path decodes are kept from the IR.
    logic [6:0] ir_op;
    logic [2:0] ir_f3;
    logic       ir_b30;
    logic [3:0] exec_ctr;
    logic       taken;
    logic       unused_instr;

    assign unused_instr = ^{mem.instr[31], mem.instr[29:15], mem.instr[11:7]};

    alu_op_decode u_alu_op_decode (
        .opcode  (ir_op),
        .f7b5    (ir_b30),
        .funct3  (ir_f3),
        .alu_ctr (exec_ctr)
    );

    assign taken   = ((ir_f3 == 3'b000) &&  alu_zero) ||
                     ((ir_f3 == 3'b001) && !alu_zero);
    assign state_o = rst_n ? state : S_FETCH;

`ifdef ILLEGAL_TRAP_EN
    assign illegal_o = rst_n && (state == S_TRAP);
`endif

    // State, IR fields and retire counter; reset abandons any instruction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            ir_op   <= '0;
            ir_f3   <= '0;
            ir_b30  <= 1'b0;
            instret <= '0;
        end else begin
            state <= state_nxt;
            if (ir_write) begin
                ir_op  <= mem.instr[6:0];
                ir_f3  <= mem.instr[14:12];
                ir_b30 <= mem.instr[30];
            end
            if (retire) instret <= instret + 1'b1;
        end
    end

    // Next state and Moore outputs; handshake strobes qualified by ready
    always_comb begin
        state_nxt    = state;
        retire       = 1'b0;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_PC4;
        alu_src_a    = 1'b0;
        alu_src_b    = ALUB_RS2;
        alu_ctr      = '0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        tgt_write    = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem.imem_req = 1'b1;
                    if (mem.imem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        state_nxt = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Precompute the branch target while the opcode is decoded
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_IMM;
                    alu_ctr   = ALUCTR_W'(ALU_ADD);
                    tgt_write = 1'b1;
                    case (ir_op)
                        OP_R, OP_I:   state_nxt = S_EXEC;
                        OP_LD, OP_ST: state_nxt = S_ADDR;
                        OP_BR:        state_nxt = S_BRANCH;
                        default: begin
`ifdef ILLEGAL_TRAP_EN
                            state_nxt = S_TRAP;
`else
                            state_nxt = S_FETCH;
                            retire    = 1'b1;
`endif
                        end
                    endcase
                end
                S_EXEC: begin
                    alu_src_b = (ir_op == OP_R) ? ALUB_RS2 : ALUB_IMM;
                    alu_ctr   = ALUCTR_W'(exec_ctr);
                    state_nxt = S_WB;
                end
                S_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
                S_ADDR: begin
                    alu_src_b = ALUB_IMM;
                    alu_ctr   = ALUCTR_W'(ALU_ADD);
                    state_nxt = S_MEM;
                end
                S_MEM: begin
                    mem.dmem_req = 1'b1;
                    mem.dmem_we  = (ir_op == OP_ST);
                    if (mem.dmem_ready) begin
                        if (ir_op == OP_ST) begin
                            retire    = 1'b1;
                            state_nxt = S_FETCH;
                        end else begin
                            state_nxt = S_LDWB;
                        end
                    end
                end
                S_LDWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                    state_nxt  = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_b = ALUB_RS2;
                    alu_ctr   = ALUCTR_W'(ALU_SUB);
                    pc_src    = PC_SRC_TGT;
                    pc_write  = taken;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
`ifdef ILLEGAL_TRAP_EN
                // Parked until reset, all outputs low
                S_TRAP: state_nxt = S_TRAP;
`endif
                default: state_nxt = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: scripted cycle-by-cycle expectations queued as
// stimulus is driven, popped and compared on the falling edge.
module tb_multicycle_ctrl_fsm;

    localparam int          TB_RET_W = 4;
    localparam logic [31:0] JUNK     = 32'hFFFF_FFFF;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [17:0] c;
        logic [31:0] ret;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic                alu_zero;
    logic                ir_write, pc_write, alu_src_a, reg_write, mem_to_reg, tgt_write;
    logic [1:0]          pc_src, alu_src_b;
    logic [3:0]          alu_ctr;
    logic [TB_RET_W-1:0] instret;
    logic [3:0]          state_o;
    logic                ill;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_ret = 0;
    exp_t q[$];

    multicycle_ctrl_fsm_if bus ();

    multicycle_ctrl_fsm #(.RET_W(TB_RET_W), .ALUCTR_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem        (bus),
        .alu_zero   (alu_zero),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctr    (alu_ctr),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .tgt_write  (tgt_write),
        .instret    (instret),
        .state_o    (state_o)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal_o  (ill)
`endif
    );

`ifndef ILLEGAL_TRAP_EN
    assign ill = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] cw(bit imr, bit dmr, bit we, bit irw, bit pcw,
                                       bit [1:0] pcs, bit asa, bit [1:0] asb,
                                       bit [3:0] ac, bit rw, bit m2r, bit tw);
        return {1'b0, imr, dmr, we, irw, pcw, pcs, asa, asb, ac, rw, m2r, tw};
    endfunction

    // Scoreboard consumer: one expectation per cycle, sampled mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.tag, ".state"}, 32'(state_o), 32'(e.st));
            chk({e.tag, ".ctl"},
                32'({ill, bus.imem_req, bus.dmem_req, bus.dmem_we, ir_write, pc_write,
                     pc_src, alu_src_a, alu_src_b, alu_ctr, reg_write, mem_to_reg, tgt_write}),
                32'(e.c));
            chk({e.tag, ".instret"}, 32'(instret), e.ret);
        end
    end

    task automatic cyc(input logic rn, input logic ir_rdy, input logic dr_rdy, input logic az,
                       input logic [31:0] ins, input string tag, input logic [3:0] st,
                       input logic [17:0] c);
        exp_t e;
        rst_n          = rn;
        bus.imem_ready = ir_rdy;
        bus.dmem_ready = dr_rdy;
        alu_zero       = az;
        bus.instr      = ins;
        e.tag = tag;
        e.st  = st;
        e.c   = c;
        e.ret = 32'(exp_ret) & ((32'd1 << TB_RET_W) - 1);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ins, input int waits);
        for (int i = 0; i < waits; i++)
            cyc(1, 0, 0, 0, ins, "fetch_wait", 4'd0, cw(1,0,0,0,0,2'b00,0,2'b00,4'h0,0,0,0));
        cyc(1, 1, 0, 0, ins, "fetch", 4'd0, cw(1,0,0,1,1,2'b00,0,2'b00,4'h0,0,0,0));
    endtask

    // imem_ready stays high outside FETCH and must be ignored
    task automatic decode();
        cyc(1, 1, 0, 0, JUNK, "decode", 4'd1, cw(0,0,0,0,0,2'b00,1,2'b01,4'h0,0,0,1));
    endtask

    task automatic run_alu(input logic [31:0] ins, input bit isr, input logic [3:0] ac,
                           input string tag);
        fetch(ins, 0);
        decode();
        cyc(1, 1, 0, 0, JUNK, {"exec_", tag}, 4'd2,
            cw(0,0,0,0,0,2'b00,0,isr ? 2'b00 : 2'b01,ac,0,0,0));
        cyc(1, 1, 0, 0, JUNK, {"wb_", tag}, 4'd3, cw(0,0,0,0,0,2'b00,0,2'b00,4'h0,1,0,0));
        exp_ret++;
    endtask

    task automatic run_ld(input logic [31:0] ins, input int waits);
        fetch(ins, 1);
        decode();
        cyc(1, 0, 1, 0, JUNK, "addr_ld", 4'd4, cw(0,0,0,0,0,2'b00,0,2'b01,4'h0,0,0,0));
        for (int i = 0; i < waits; i++)
            cyc(1, 0, 0, 0, JUNK, "mem_ld_wait", 4'd5, cw(0,1,0,0,0,2'b00,0,2'b00,4'h0,0,0,0));
        cyc(1, 0, 1, 0, JUNK, "mem_ld", 4'd5, cw(0,1,0,0,0,2'b00,0,2'b00,4'h0,0,0,0));
        cyc(1, 0, 0, 0, JUNK, "ldwb", 4'd6, cw(0,0,0,0,0,2'b00,0,2'b00,4'h0,1,1,0));
        exp_ret++;
    endtask

    task automatic run_st(input logic [31:0] ins);
        fetch(ins, 0);
        decode();
        cyc(1, 0, 0, 0, JUNK, "addr_st", 4'd4, cw(0,0,0,0,0,2'b00,0,2'b01,4'h0,0,0,0));
        cyc(1, 0, 1, 0, JUNK, "mem_st", 4'd5, cw(0,1,1,0,0,2'b00,0,2'b00,4'h0,0,0,0));
        exp_ret++;
    endtask

    task automatic run_br(input logic [31:0] ins, input logic az, input bit tk, input string tag);
        fetch(ins, 0);
        decode();
        cyc(1, 0, 0, az, JUNK, tag, 4'd7, cw(0,0,0,0,tk,2'b01,0,2'b00,4'h1,0,0,0));
        exp_ret++;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.instr      = 32'h0;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b1;
        alu_zero       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset: outputs forced low even with readies high
        cyc(0, 1, 1, 1, 32'h00208033, "reset", 4'd0, 18'h0);

        run_alu(32'h00208033, 1, 4'b0000, "add");
        run_ld (32'h0000A083, 3);
        run_st (32'h0020A023);
        run_br (32'h00209463, 1'b0, 1, "bne_taken");
        run_br (32'h00209463, 1'b1, 0, "bne_not");
        run_br (32'h00208463, 1'b1, 1, "beq_taken");
        run_br (32'h0020C463, 1'b0, 0, "blt_as_not");
        run_alu(32'h40208033, 1, 4'b0001, "sub");
        run_alu(32'h4020D033, 1, 4'b1000, "sra");
        run_alu(32'h0020A033, 1, 4'b0101, "slt");
        run_alu(32'h0020C033, 1, 4'b0100, "xor");
        run_alu(32'h0020B033, 1, 4'b0000, "sltu_add");
        run_alu(32'h0010D093, 0, 4'b0111, "srli");
        run_alu(32'h4010D093, 0, 4'b1000, "srai");
        run_alu(32'h40008093, 0, 4'b0000, "addi_b30");

        // Illegal opcode
        fetch(32'h0000007F, 0);
        decode();
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++)
            cyc(1, 1, 1, 0, JUNK, "trap", 4'd8, 18'h20000);
        cyc(0, 1, 1, 0, JUNK, "trap_rst", 4'd0, 18'h0);
        exp_ret = 0;
`else
        exp_ret++;
`endif
        cyc(1, 0, 0, 0, JUNK, "after_illegal", 4'd0, cw(1,0,0,0,0,2'b00,0,2'b00,4'h0,0,0,0));

        // Reset in MEM: ready asserted, but the load is abandoned
        fetch(32'h0000A083, 0);
        decode();
        cyc(1, 0, 0, 0, JUNK, "addr_pre_rst", 4'd4, cw(0,0,0,0,0,2'b00,0,2'b01,4'h0,0,0,0));
        cyc(0, 0, 1, 0, JUNK, "rst_in_mem", 4'd0, 18'h0);
        exp_ret = 0;
        cyc(1, 0, 0, 0, JUNK, "post_rst", 4'd0, cw(1,0,0,0,0,2'b00,0,2'b00,4'h0,0,0,0));

        // Counter wrap at 2^4: 15 retires reach 15, the 16th returns to 0
        for (int i = 0; i < 16; i++)
            run_br(32'h00209463, 1'b1, 0, "wrap_br");
        cyc(1, 0, 0, 0, JUNK, "wrap_zero", 4'd0, cw(1,0,0,0,0,2'b00,0,2'b00,4'h0,0,0,0));

        chk("sb_drain", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
